// File: rtl/hazard_control_unit_pkg.sv
// Shared constants, control bundle type and helpers for the hazard control unit.
// Decode values for forwarding selects, result source and FSM states live here.
package hazard_control_unit_pkg;

    localparam logic [1:0] FWD_RF          = 2'b00;
    localparam logic [1:0] FWD_WB          = 2'b01;
    localparam logic [1:0] FWD_MEM         = 2'b10;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic flush_d;
        logic flush_e;
        logic flush_m;
    } pipe_ctrl_t;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_control_unit_fwd_select.sv
// Combinational operand forwarding select for one execute-stage source register.
// The memory stage holds the younger result, so it is preferred over writeback.
module fwd_select
    import hazard_control_unit_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && reg_match(rd_m, rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && reg_match(rd_w, rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: forwarding, load-use stalls, branch flushes and mul/div sequencing.
// Define HAZARD_PERF_CNT_EN to build the saturating StallCount/FlushCount performance counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 64,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    input  logic             MdDoneE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MdBusy,
    output logic             MdTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int WD_W = $clog2(MD_MAX_CYCLES + 1);

    logic [0:0]      state;
    logic [0:0]      state_next;
    logic [WD_W-1:0] watchdog;
    logic [WD_W-1:0] watchdog_next;
    logic            timeout_flag;
    logic            lw_stall;
    logic            md_abort;
    pipe_ctrl_t      ctrl;

    fwd_select u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (ForwardAE)
    );

    fwd_select u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (ForwardBE)
    );

    always_comb begin
        lw_stall = (ResultSrcE == RESULT_SRC_LOAD) &&
                   (reg_match(RdE, Rs1D) || reg_match(RdE, Rs2D));
        md_abort = (state == ST_MD_BUSY) && !MdDoneE &&
                   (watchdog == WD_W'(MD_MAX_CYCLES));
    end

    // While busy the front of the pipe freezes and M is fed bubbles until the result lands.
    always_comb begin
        ctrl = '0;
        if (state == ST_IDLE) begin
            ctrl.stall_f = lw_stall;
            ctrl.stall_d = lw_stall;
            ctrl.flush_d = PCSrcE;
            ctrl.flush_e = lw_stall || PCSrcE;
        end else begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.flush_e = md_abort;
            ctrl.flush_m = !MdDoneE;
        end
    end

    always_comb begin
        state_next    = state;
        watchdog_next = watchdog;
        if (state == ST_IDLE) begin
            // A redirect squashes the op; a same-cycle done finishes it without leaving IDLE.
            if (MdStartE && !PCSrcE && !MdDoneE) begin
                state_next    = ST_MD_BUSY;
                watchdog_next = WD_W'(1);
            end
        end else if (MdDoneE || md_abort) begin
            state_next    = ST_IDLE;
            watchdog_next = '0;
        end else begin
            watchdog_next = watchdog + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            watchdog     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state    <= state_next;
            watchdog <= watchdog_next;
            if (md_abort) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign StallF    = ctrl.stall_f;
    assign StallD    = ctrl.stall_d;
    assign StallE    = ctrl.stall_e;
    assign FlushD    = ctrl.flush_d;
    assign FlushE    = ctrl.flush_e;
    assign FlushM    = ctrl.flush_m;
    assign MdBusy    = (state == ST_MD_BUSY);
    assign MdTimeout = timeout_flag;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             branch_flush;

    assign branch_flush = (state == ST_IDLE) && PCSrcE;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (ctrl.stall_f && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (branch_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    assign StallCount = stall_count;
    assign FlushCount = flush_count;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
